fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the 8-bit microprocessor. Drives the program counter's `loadPC`/`incPC`/`address` inputs and consumes its `execadd` output. Reads program memory at the current PC and presents each instruction byte to the decoder over a valid/ready handshake. Handles branch redirects from the execute stage and, optionally, a halt opcode.

## Interface
- `ADDR_W`, 6: program address width; matches the PC.
- `DATA_W`, 8: instruction width.
- `HALT_OPCODE`, 8'hFF: opcode that halts fetch when `FETCH_HALT_EN` is defined.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `execadd`  in  ADDR_W  current PC value.
- `loadPC`  out  1  one-cycle pulse; PC loads `address`.
- `incPC`  out  1  one-cycle pulse; PC increments.
- `address`  out  ADDR_W  load value for the PC.
- `mem_rd`  out  1  program-memory read strobe.
- `mem_addr`  out  ADDR_W  program-memory address.
- `mem_data`  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd`.
- `ir`  out  DATA_W  instruction register.
- `ir_valid`  out  1  `ir` holds an unconsumed instruction.
- `ir_ready`  in  1  decoder accepts `ir`.
- `branch_req`  in  1  redirect fetch; single-cycle pulse.
- `branch_target`  in  ADDR_W  redirect address.
- `halted`  out  1  sequencer is in HALT.

## Operation
- Reset values for all outputs are 0: `loadPC`, `incPC`, `address`, `mem_rd`, `mem_addr`, `ir`, `ir_valid`, `halted`. The state is IDLE.
- All outputs are registered except `loadPC`, `incPC`, `address`, `mem_rd` and `mem_addr`, which are decoded from state and inputs.
- States:
  - IDLE: assert `loadPC=1` with `address=0`, then go to FETCH.
  - FETCH: assert `mem_rd=1` with `mem_addr=execadd`, then go to WAIT.
  - WAIT: `mem_data` is valid.
    - Normally: latch `ir<=mem_data`, set `ir_valid<=1`, pulse `incPC=1`, and go to HOLD.
  - HOLD: `ir_valid=1`.
    - If `ir_ready`: clear `ir_valid` and go to FETCH.
    - Otherwise stay; `ir` is stable.
  - HALT: `halted=1`; no memory or PC activity. Only `reset` exits.
- Branch, evaluated in FETCH, WAIT and HOLD, highest priority after reset:
  - Assert `loadPC=1` with `address=branch_target`; `incPC=0` that cycle.
  - Clear `ir_valid`, discard any in-flight read, and go to FETCH.
- `branch_req` is ignored in IDLE and HALT.
- `loadPC` and `incPC` are never high in the same cycle.
- PC wrap-around (63 to 0) is the PC's arithmetic. The sequencer fetches from `execadd` unconditionally, with no range check.

## Timing
- Fetch latency: `mem_rd` in cycle N, `ir_valid` high from cycle N+2.
- Peak throughput: one instruction per 3 cycles when `ir_ready` is held high.
- `incPC` fires in WAIT, so `execadd` points at the next instruction while `ir` is presented.
- Branch in FETCH or WAIT: the read is discarded and no `incPC` occurs. The next `mem_rd` is in the following cycle at `branch_target`.
- Branch in HOLD together with `ir_ready`: the current `ir` counts as accepted, then fetch redirects.
- Branch in HOLD without `ir_ready`: `ir` is dropped (`ir_valid` falls next cycle).
- Reset mid-operation: all outputs return to reset values in the next cycle, with no `incPC`/`loadPC` pulse in the reset cycle. The IDLE pulse follows the first cycle with `reset=0`.

## Configuration
- `FETCH_HALT_EN` defined: in WAIT, `mem_data==HALT_OPCODE` means:
  - no `ir` update and no `incPC`;
  - go to HALT, with `halted=1` from the next cycle;
  - `execadd` still points at the halt instruction.
- `FETCH_HALT_EN` undefined:
  - `HALT_OPCODE` is an ordinary instruction;
  - HALT is unreachable and `halted` is tied to 0.

## Test plan
- Reset, then release: `loadPC` pulse with `address=0`, then `mem_rd` with `mem_addr=0`. Memory returns 8'h12 → `ir=8'h12`, `ir_valid=1` two cycles after `mem_rd`, and one `incPC` pulse.
- Stream with `ir_ready=1`, memory[0..3]=8'h01..8'h04: decoder receives 01,02,03,04 on cycles 3 apart; `execadd` counts 0→4.
- Backpressure: `ir_ready=0` for 5 cycles in HOLD → `ir` stable, no `mem_rd`, no `incPC`. Raising `ir_ready` → FETCH next cycle.
- Branch in WAIT to 6'd40: no `incPC`, read data discarded, next `mem_rd` has `mem_addr=40`. Branch in HOLD with `ir_ready=1`: instruction accepted once, then fetch at target.
- Wrap: `execadd=63` with memory[63]=8'h0A, then memory[0]=8'h0B → decoder sees 0A then 0B, and the PC reads 0.
- With `FETCH_HALT_EN`, memory[2]=8'hFF → two instructions delivered, then `halted=1` and `execadd=2`. `branch_req` is ignored; `reset` clears `halted`. Without the macro, 8'hFF is delivered as `ir`.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the 8-bit microprocessor.
// Sequences PC load/increment and program-memory reads, and hands each
// instruction byte to the decoder over an ir_valid/ir_ready handshake.
// Branch redirects from execute override fetch in FETCH, WAIT and HOLD.
// Optional feature macro: FETCH_HALT_EN (halt on HALT_OPCODE).
module fetch_sequencer #(
  parameter int                 ADDR_W      = 6,
  parameter int                 DATA_W      = 8,
  parameter logic [DATA_W-1:0]  HALT_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] execadd,
  output logic              loadPC,
  output logic              incPC,
  output logic [ADDR_W-1:0] address,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted
);

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t state;
  logic   branch_take;
  logic   halt_hit;

  // Branches only matter while a fetch is in progress or an instruction is held.
  assign branch_take = branch_req &&
                       ((state == S_FETCH) || (state == S_WAIT) || (state == S_HOLD));

  // Halt opcode recognised only when the feature is built in; otherwise it
  // is delivered as an ordinary instruction.
  assign halt_hit = HALT_EN && (state == S_WAIT) && (mem_data == HALT_OPCODE);

  // PC and memory strobes decoded from state; all held low while reset is high
  // so no stray pulse appears in the reset cycle.
  always_comb begin
    loadPC   = 1'b0;
    incPC    = 1'b0;
    address  = '0;
    mem_rd   = 1'b0;
    mem_addr = '0;
    if (!reset) begin
      if (branch_take) begin
        loadPC  = 1'b1;
        address = branch_target;
      end else begin
        case (state)
          S_IDLE:  loadPC = 1'b1;
          S_WAIT:  incPC  = !halt_hit;
          default: ;
        endcase
      end
      // The read still issues in FETCH under a branch; WAIT simply never
      // consumes it because the branch sends the FSM back to FETCH.
      if (state == S_FETCH) begin
        mem_rd   = 1'b1;
        mem_addr = execadd;
      end
    end
  end

  // Fetch FSM with registered instruction register, valid flag and halt flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ir       <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else if (branch_take) begin
      ir_valid <= 1'b0;
      state    <= S_FETCH;
    end else begin
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (halt_hit) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            ir       <= mem_data;
            ir_valid <= 1'b1;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: surrounds the DUT with a PC and a
// one-cycle-latency program memory, and checks each delivered instruction
// against a transaction-level model (next-instruction address plus memory image).
module tb_fetch_sequencer;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] execadd = '0;
  logic          loadPC, incPC, mem_rd, ir_valid, halted;
  logic [AW-1:0] address, mem_addr;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] ir;
  logic          ir_ready = 1'b0;
  logic          branch_req = 1'b0;
  logic [AW-1:0] branch_target = '0;

  logic [DW-1:0] mem [64];

  int total = 0;
  int bad   = 0;
  int pc_m  = 0;   // address of the next instruction the decoder should receive
  int delivered = 0;

  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .HALT_OPCODE(8'hFF)) dut (
    .clk(clk), .reset(reset), .execadd(execadd),
    .loadPC(loadPC), .incPC(incPC), .address(address),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .branch_req(branch_req), .branch_target(branch_target),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Environment: program counter and synchronous program memory.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
    if (loadPC)     execadd <= address;
    else if (incPC) execadd <= execadd + 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, drive this cycle's inputs, then let outputs settle.
  task automatic go(input logic rst, input logic br, input logic [AW-1:0] tgt, input logic rdy);
    @(posedge clk); #1;
    reset = rst; branch_req = br; branch_target = tgt; ir_ready = rdy;
    #1;
    chk("ld_inc_excl", 32'(loadPC & incPC), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ld"},   loadPC, 0);
    chk({tag, "_inc"},  incPC, 0);
    chk({tag, "_addr"}, address, 0);
    chk({tag, "_rd"},   mem_rd, 0);
    chk({tag, "_madr"}, mem_addr, 0);
    chk({tag, "_ir"},   ir, 0);
    chk({tag, "_iv"},   ir_valid, 0);
    chk({tag, "_hlt"},  halted, 0);
  endtask

  // First cycle out of reset: PC load of address 0.
  task automatic release_reset();
    go(1'b0, 1'b0, '0, 1'b0);
    chk("idle_ld", loadPC, 1);
    chk("idle_addr", address, 0);
    chk("idle_rd", mem_rd, 0);
    pc_m = 0;
  endtask

  // One full instruction delivery with 'delay' cycles of decoder backpressure.
  task automatic fetch_one(input int delay);
    logic [DW-1:0] d;
    int nxt;
    d   = mem[pc_m];
    nxt = (pc_m + 1) % 64;
    go(1'b0, 1'b0, '0, 1'($urandom));
    chk("fetch_rd", mem_rd, 1);
    chk("fetch_addr", mem_addr, pc_m);
    chk("fetch_ld", loadPC, 0);
    chk("fetch_iv", ir_valid, 0);
    go(1'b0, 1'b0, '0, 1'($urandom));
    chk("wait_inc", incPC, 1);
    chk("wait_rd", mem_rd, 0);
    chk("wait_iv", ir_valid, 0);
    for (int i = 0; i < delay; i++) begin
      go(1'b0, 1'b0, '0, 1'b0);
      chk("hold_iv", ir_valid, 1);
      chk("hold_ir", ir, d);
      chk("hold_rd", mem_rd, 0);
      chk("hold_inc", incPC, 0);
      chk("hold_pc", execadd, nxt);
    end
    go(1'b0, 1'b0, '0, 1'b1);
    chk("acc_iv", ir_valid, 1);
    chk("acc_ir", ir, d);
    delivered++;
    pc_m = nxt;
  endtask

  // Redirect while in FETCH (phase 0), WAIT (1) or HOLD (2).
  task automatic branch_at(input int phase, input logic [AW-1:0] tgt, input logic rdy);
    logic [DW-1:0] d;
    d = mem[pc_m];
    if (phase >= 1) begin
      go(1'b0, 1'b0, '0, 1'b0);
      chk("bpre_rd", mem_rd, 1);
    end
    if (phase == 2) begin
      go(1'b0, 1'b0, '0, 1'b0);
      chk("bpre_inc", incPC, 1);
    end
    go(1'b0, 1'b1, tgt, rdy);
    chk("br_ld", loadPC, 1);
    chk("br_addr", address, tgt);
    chk("br_inc", incPC, 0);
    if (phase == 2) begin
      chk("br_hold_iv", ir_valid, 1);
      chk("br_hold_ir", ir, d);
      if (rdy) delivered++;
    end
    pc_m = int'(tgt);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'($urandom);
      if (mem[i] == 8'hFF) mem[i] = 8'h5A;
    end

    // Reset values
    go(1'b1, 1'b0, '0, 1'b0);
    go(1'b1, 1'b0, '0, 1'b0);
    chk_all_zero("rst");

    // First fetch: 8'h12 from address 0
    mem[0] = 8'h12;
    release_reset();
    fetch_one(1);

    // Reset while a read is in flight: no PC pulses, registers clear
    go(1'b0, 1'b0, '0, 1'b0);
    chk("mid_fetch_rd", mem_rd, 1);
    go(1'b1, 1'b0, '0, 1'b0);
    chk("mid_rst_inc", incPC, 0);
    chk("mid_rst_ld", loadPC, 0);
    go(1'b1, 1'b0, '0, 1'b0);
    chk_all_zero("mid_rst");

    // Streaming 01..04 at full throughput
    for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
    release_reset();
    for (int i = 0; i < 4; i++) fetch_one(0);
    go(1'b0, 1'b0, '0, 1'b0);
    chk("stream_pc", execadd, 4);
    chk("stream_rd", mem_rd, 1);
    chk("stream_madr", mem_addr, 4);
    // finish the in-flight fetch at address 4 with 5 cycles of backpressure
    go(1'b0, 1'b0, '0, 1'b0);
    chk("bp_wait_inc", incPC, 1);
    for (int i = 0; i < 5; i++) begin
      go(1'b0, 1'b0, '0, 1'b0);
      chk("bp_ir", ir, mem[4]);
      chk("bp_rd", mem_rd, 0);
      chk("bp_inc", incPC, 0);
    end
    go(1'b0, 1'b0, '0, 1'b1);
    chk("bp_acc_iv", ir_valid, 1);
    pc_m = 5;
    fetch_one(5);

    // Branch in WAIT to 40, then branch in HOLD with ir_ready
    branch_at(1, 6'd40, 1'b0);
    fetch_one(0);
    branch_at(2, 6'd17, 1'b1);
    fetch_one(2);
    branch_at(2, 6'd30, 1'b0);
    fetch_one(1);
    branch_at(0, 6'd9, 1'b1);
    fetch_one(0);

    // Wrap-around 63 -> 0
    mem[63] = 8'h0A;
    mem[0]  = 8'h0B;
    branch_at(0, 6'd63, 1'b0);
    fetch_one(1);
    fetch_one(1);

    // Randomized mix of deliveries and redirects
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        branch_at(int'($urandom_range(0, 2)), 6'($urandom), 1'($urandom));
      else
        fetch_one(int'($urandom_range(0, 3)));
    end

    // Halt opcode at address 2
    go(1'b1, 1'b0, '0, 1'b0);
    go(1'b1, 1'b0, '0, 1'b0);
    mem[0] = 8'h21;
    mem[1] = 8'h22;
    mem[2] = 8'hFF;
    release_reset();
    fetch_one(0);
    fetch_one(0);
`ifdef FETCH_HALT_EN
    go(1'b0, 1'b0, '0, 1'b0);
    chk("h_fetch_madr", mem_addr, 2);
    go(1'b0, 1'b0, '0, 1'b0);
    chk("h_wait_inc", incPC, 0);
    for (int i = 0; i < 4; i++) begin
      go(1'b0, 1'b1, 6'd17, 1'b1);
      chk("h_halted", halted, 1);
      chk("h_ld", loadPC, 0);
      chk("h_rd", mem_rd, 0);
      chk("h_iv", ir_valid, 0);
      chk("h_pc", execadd, 2);
    end
    go(1'b1, 1'b0, '0, 1'b0);
    go(1'b1, 1'b0, '0, 1'b0);
    chk("h_rst_halted", halted, 0);
`else
    fetch_one(2);
    chk("ff_halted", halted, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
